// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, FSM encoding and width helpers for the systolic feeder.
package systolic_pkg;
  localparam int N_DEF = 32;
  localparam int K_DEF = 4;
  localparam int LANE_W = N_DEF;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;
  // Holds t up to 2K-2 and the lane offsets t-i without wrap.
  function automatic int cnt_w(input int k);
    return $clog2(k) + 2;
  endfunction
endpackage

// File: rtl/matrix_buffer.sv
// matrix_buffer: KxK word register array, one write port, full parallel read, async active-low clear.
module matrix_buffer #(
  parameter int N  = 32,
  parameter int K  = 4,
  parameter int IW = $clog2(K)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we_i,
  input  logic [IW-1:0]     row_i,
  input  logic [IW-1:0]     col_i,
  input  logic [N-1:0]      data_i,
  output logic [K*K*N-1:0]  rd_o
);
  logic [N-1:0] mem_q [K][K];
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          mem_q[r][c] <= '0;
    end else if (we_i) begin
      mem_q[row_i][col_i] <= data_i;
    end
  always_comb
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        rd_o[(r*K+c)*N +: N] = mem_q[r][c];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers operand matrices A and B and streams them diagonally skewed
// into the PE grid, then drains for K cycles and pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = LANE_W,
  parameter int K  = K_DEF,
  parameter int IW = $clog2(K)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [N-1:0]    wr_data,
  input  logic            start,
  output logic [K*N-1:0]  a_out,
  output logic [K-1:0]    a_vld,
  output logic [K*N-1:0]  b_out,
  output logic [K-1:0]    b_vld,
  output logic            busy,
  output logic            done
);
  localparam int CW = cnt_w(K);
  localparam logic [CW-1:0] T_LAST = CW'(2*K-2);
  localparam logic [CW-1:0] D_LAST = CW'(K-1);
  state_e            state_q;
  logic [CW-1:0]     t_q, tn, k;
  logic [K*K*N-1:0]  a_rd, b_rd;
  logic [K*N-1:0]    a_lane, b_lane;
  logic [K-1:0]      v;
  logic              idle, feed, we;
  assign idle = state_q == IDLE;
  assign we   = wr_en && idle && !start;
  assign feed = (idle && start) || (state_q == STREAM && t_q != T_LAST);
  matrix_buffer #(.N(N), .K(K), .IW(IW)) u_a (
    .clk(clk), .clr(clr), .we_i(we && !wr_sel), .row_i(wr_row), .col_i(wr_col),
    .data_i(wr_data), .rd_o(a_rd)
  );
  matrix_buffer #(.N(N), .K(K), .IW(IW)) u_b (
    .clk(clk), .clr(clr), .we_i(we && wr_sel), .row_i(wr_row), .col_i(wr_col),
    .data_i(wr_data), .rd_o(b_rd)
  );
  // Lane values for the t presented next cycle; lane i is live while 0 <= t-i <= K-1.
  always_comb begin
    tn = idle ? '0 : t_q + 1'b1;
    k = '0;
    v = '0;
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < K; i++) begin
      k = tn - CW'(i);
      v[i] = tn >= CW'(i) && k < CW'(K);
      a_lane[i*N +: N] = v[i] ? a_rd[(i*K + int'(k[IW-1:0]))*N +: N] : '0;
      b_lane[i*N +: N] = v[i] ? b_rd[(int'(k[IW-1:0])*K + i)*N +: N] : '0;
    end
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_out   <= '0;
      b_out   <= '0;
      a_vld   <= '0;
      b_vld   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a_out <= feed ? a_lane : '0;
      b_out <= feed ? b_lane : '0;
      a_vld <= feed ? v : '0;
      b_vld <= feed ? v : '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= STREAM;
          t_q     <= '0;
          busy    <= 1'b1;
        end
        STREAM: if (t_q == T_LAST) begin
          state_q <= DRAIN;
          t_q     <= '0;
        end else t_q <= t_q + 1'b1;
        DRAIN: if (t_q == D_LAST) begin
          state_q <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else t_q <= t_q + 1'b1;
        default: begin
          state_q <= IDLE;
          t_q     <= '0;
          done    <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic array. Holds one K×K operand matrix A and one K×K operand matrix B, loaded word by word.
- On start, streams them into the Processing_Element grid with diagonal skew: A row i enters the left edge of array row i, delayed i cycles; B column j enters the top edge of array column j, delayed j cycles.
- Provides busy/done so the controller knows when the array has been fed and drained.

Parameters:
- N, 32, data word width; matches the Processing_Element data width.
- K, 4, array dimension (K×K PEs); legal values 2..16.
- IW, $clog2(K), row/column index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- wr_en  in  1  write one operand word this cycle
- wr_sel  in  1  0 = write matrix A, 1 = write matrix B
- wr_row  in  IW  row index of the word being written
- wr_col  in  IW  column index of the word being written
- wr_data  in  N  operand word
- start  in  1  single-cycle request to begin streaming
- a_out  out  K*N  A lanes; lane i at bits [i*N +: N] drives array row i
- a_vld  out  K  per-lane valid for a_out
- b_out  out  K*N  B lanes; lane j at bits [j*N +: N] drives array column j
- b_vld  out  K  per-lane valid for b_out
- busy  out  1  high while streaming or draining
- done  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset (clr=0, asynchronous):
  - All A/B buffer words are 0.
  - a_out, b_out, a_vld, b_vld, busy and done are 0.
  - FSM goes to IDLE and the counter is 0.
  - Reset mid-operation aborts immediately; outputs go to 0 without waiting for a clock edge.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - A write (wr_en=1) updates buf_sel[wr_row][wr_col] at the clock edge.
  - start=1 moves the FSM to STREAM with counter t=0.
  - If wr_en and start are both high in the same cycle, start wins and the write is dropped.
- STREAM:
  - Outputs are registered. Cycle c=0 is the first cycle after the start edge, and that cycle presents t=0.
  - t increments by 1 each cycle, for t = 0..2K-2 (2K-1 cycles).
  - A lane i: if 0 ≤ t-i ≤ K-1, a_out lane i = A[i][t-i] and a_vld[i]=1; otherwise the lane is 0 and a_vld[i]=0.
  - B lane j: if 0 ≤ t-j ≤ K-1, b_out lane j = B[t-j][j] and b_vld[j]=1; otherwise the lane is 0 and b_vld[j]=0.
  - At t=2K-2 the FSM moves to DRAIN and the counter resets to 0.
- DRAIN:
  - Lasts K cycles, so the last operands can propagate through the PE grid.
  - All lanes and all valids are 0.
  - busy stays high. After K cycles the FSM moves to DONE.
- DONE:
  - Lasts exactly one cycle, at cycle c=3K-1 after start.
  - done=1 and busy=0; the FSM then returns to IDLE.
- busy is 1 for cycles c=0..3K-2 inclusive, and 0 otherwise.
- While busy or in DONE:
  - wr_en is ignored and buffers are unchanged.
  - start is ignored; it is not queued.
- Buffers persist across operations. A second start with no new writes replays the same matrices.
- Data passes unmodified; no arithmetic is performed. Only the counter compares t against the lane index, at IW+2 bits wide.

Decomposition:
- Shared package systolic_pkg holds:
  - defaults N=32 and K=4;
  - the FSM state encoding (IDLE, STREAM, DRAIN, DONE);
  - the lane-slice width constant and the derived counter width.
- One sub-module, matrix_buffer: a K×K×N register array with an async-active-low clear, one write port and full parallel read. It is instantiated twice, once for A and once for B.
- The skew/select logic and the FSM live in systolic_feeder.

Test Plan:
- Reset then idle, K=4, clr low for 2 cycles → a_out=b_out=0, a_vld=b_vld=0, busy=0 and done=0 throughout, including while clr is held low.
- Load A[i][k]=10*i+k+1 and B[k][j]=100+10*k+j, then pulse start → the following must all hold:
  - c=0: a_vld=4'b0001, a_out lane0=1, b_out lane0=100.
  - c=3: a_vld=4'b1111; lanes are A[0][3]=4, A[1][2]=13, A[2][1]=22, A[3][0]=31.
  - c=6: only lane3 valid, a_out lane3=34 and b_out lane3=133.
- Timing of the same run → busy high for cycles c=0..10, done high only at c=11, all valids 0 during c=7..10.
- Start and wr_en high together in IDLE, writing A[0][0]=99 → stream shows A[0][0]=1 at c=0, and the buffer still holds 1 afterwards.
- wr_en writing A[0][0]=77 at c=2, and a start pulse at c=5 → no effect: the stream is unchanged and no second operation follows done. A later start with no writes replays A[0][0]=1.
- clr pulsed low at c=4 → all outputs 0 immediately, FSM back in IDLE, buffers zeroed. A subsequent start streams all-zero data with correct a_vld/b_vld timing.
